// File: rtl/cdb_broadcaster_if.sv
// Completion-side bus bundle for cdb_broadcaster: functional-unit results in,
// squash control in, registered common-data-bus broadcast out.
interface cdb_broadcaster_if #(
  parameter int NUM_FU  = 4,
  parameter int Q_DEPTH = 2,
  parameter int ROB_SZ  = 8,
  parameter int XLEN    = 32,
  parameter int TAG_W   = $clog2(ROB_SZ + 1),
  parameter int CNT_W   = $clog2(NUM_FU * Q_DEPTH + 1)
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_mispred;
  logic [NUM_FU*XLEN-1:0]  fu_branch_loc;
  logic [NUM_FU-1:0]       fu_ready;
  logic [TAG_W-1:0]        rob_head;
  logic                    branch_valid;
  logic [TAG_W-1:0]        branch_tag;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_v;
  logic                    cdb_mispred;
  logic [XLEN-1:0]         cdb_branch_loc;
  logic [CNT_W-1:0]        pending_cnt;

  // Environment side: functional units, ROB head and branch unit.
  modport master (
    output fu_valid, fu_tag, fu_value, fu_mispred, fu_branch_loc,
    output rob_head, branch_valid, branch_tag,
    input  fu_ready, cdb_tag, cdb_v, cdb_mispred, cdb_branch_loc, pending_cnt
  );

  // Broadcaster side.
  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_mispred, fu_branch_loc,
    input  rob_head, branch_valid, branch_tag,
    output fu_ready, cdb_tag, cdb_v, cdb_mispred, cdb_branch_loc, pending_cnt
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common-data-bus driver: buffers finished results in per-unit slots, broadcasts
// the oldest one (by ROB age) each cycle, and drops results younger than a
// mispredicted branch on squash.
module cdb_broadcaster #(
  parameter int NUM_FU  = 4,
  parameter int Q_DEPTH = 2,
  parameter int ROB_SZ  = 8,
  parameter int XLEN    = 32,
  parameter int TAG_W   = $clog2(ROB_SZ + 1),
  parameter int CNT_W   = $clog2(NUM_FU * Q_DEPTH + 1)
) (
  input logic               clock,
  input logic               reset,
  cdb_broadcaster_if.slave  bus
);
  localparam int NUM_SLOTS = NUM_FU * Q_DEPTH;
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [TAG_W:0] ROB_SZ_E = (TAG_W + 1)'(ROB_SZ);

  // Distance from the ROB head; tags and head are both in 1..ROB_SZ, so one
  // conditional subtract replaces the modulo.
  function automatic logic [TAG_W:0] age_of(input logic [TAG_W-1:0] tag,
                                            input logic [TAG_W-1:0] head);
    logic [TAG_W:0] diff;
    diff = {1'b0, tag} + ROB_SZ_E - {1'b0, head};
    if (diff >= ROB_SZ_E) diff = diff - ROB_SZ_E;
    return diff;
  endfunction

  logic [NUM_SLOTS-1:0] valid_reg, valid_next;
  logic [NUM_SLOTS-1:0] wr_en, kill_vec, pop_vec;
  logic [TAG_W-1:0]     tag_reg     [NUM_SLOTS];
  logic [XLEN-1:0]      value_reg   [NUM_SLOTS];
  logic                 mispred_reg [NUM_SLOTS];
  logic [XLEN-1:0]      loc_reg     [NUM_SLOTS];
  logic [TAG_W:0]       slot_age    [NUM_SLOTS];
  logic [TAG_W:0]       br_age;

  logic                 sel_found;
  logic [SLOT_W-1:0]    sel_idx;
  logic [TAG_W:0]       sel_age;

  logic [TAG_W-1:0]     cdb_tag_reg, cdb_tag_next;
  logic [XLEN-1:0]      cdb_v_reg, cdb_v_next;
  logic                 cdb_mispred_reg, cdb_mispred_next;
  logic [XLEN-1:0]      cdb_loc_reg, cdb_loc_next;
  logic [CNT_W-1:0]     pending_reg, pending_next;

  assign br_age = age_of(bus.branch_tag, bus.rob_head);

  genvar gi;
  // Per unit: readiness from current state only, lowest free slot takes the
  // incoming result unless a same-edge squash makes it dead on arrival.
  for (gi = 0; gi < NUM_FU; gi++) begin : g_unit
    logic [Q_DEPTH-1:0] free_vec;
    logic [Q_DEPTH-1:0] pick_vec;
    logic               in_young;
    assign free_vec = ~valid_reg[gi*Q_DEPTH +: Q_DEPTH];
    assign pick_vec = free_vec & (~free_vec + Q_DEPTH'(1));
    assign in_young = bus.branch_valid &&
                      (age_of(bus.fu_tag[gi*TAG_W +: TAG_W], bus.rob_head) > br_age);
    assign bus.fu_ready[gi] = |free_vec;
    assign wr_en[gi*Q_DEPTH +: Q_DEPTH] = (bus.fu_valid[gi] && !in_young) ? pick_vec : '0;
  end

  // Per slot: age relative to the head and squash kill flag.
  for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign slot_age[gi] = age_of(tag_reg[gi], bus.rob_head);
    assign kill_vec[gi] = bus.branch_valid && valid_reg[gi] && (slot_age[gi] > br_age);
  end

  // Oldest valid slot wins; tags are unique so strict less-than is enough.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (valid_reg[s] && (!sel_found || slot_age[s] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = SLOT_W'(s);
        sel_age   = slot_age[s];
      end
    end
  end

  // Next slot occupancy and broadcast; a squashed winner still leaves its slot
  // but nothing else is broadcast in its place.
  always_comb begin
    pop_vec = '0;
    if (sel_found) pop_vec[sel_idx] = 1'b1;
    valid_next = (valid_reg & ~pop_vec & ~kill_vec) | wr_en;

    cdb_tag_next     = '0;
    cdb_v_next       = '0;
    cdb_mispred_next = 1'b0;
    cdb_loc_next     = '0;
    if (sel_found && !kill_vec[sel_idx]) begin
      cdb_tag_next     = tag_reg[sel_idx];
      cdb_v_next       = value_reg[sel_idx];
      cdb_mispred_next = mispred_reg[sel_idx];
      cdb_loc_next     = loc_reg[sel_idx];
    end
  end

  // Population count of slots that stay valid after this edge.
  always_comb begin
    pending_next = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      pending_next = pending_next + CNT_W'(valid_next[s]);
    end
  end

  // Control state and broadcast registers; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg       <= '0;
      cdb_tag_reg     <= '0;
      cdb_v_reg       <= '0;
      cdb_mispred_reg <= 1'b0;
      cdb_loc_reg     <= '0;
      pending_reg     <= '0;
    end else begin
      valid_reg       <= valid_next;
      cdb_tag_reg     <= cdb_tag_next;
      cdb_v_reg       <= cdb_v_next;
      cdb_mispred_reg <= cdb_mispred_next;
      cdb_loc_reg     <= cdb_loc_next;
      pending_reg     <= pending_next;
    end
  end

  // Slot payload is only meaningful while valid_reg is set, so it carries no reset.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wr_en[s]) begin
        tag_reg[s]     <= bus.fu_tag[(s / Q_DEPTH) * TAG_W +: TAG_W];
        value_reg[s]   <= bus.fu_value[(s / Q_DEPTH) * XLEN +: XLEN];
        mispred_reg[s] <= bus.fu_mispred[s / Q_DEPTH];
        loc_reg[s]     <= bus.fu_branch_loc[(s / Q_DEPTH) * XLEN +: XLEN];
      end
    end
  end

  assign bus.cdb_tag        = cdb_tag_reg;
  assign bus.cdb_v          = cdb_v_reg;
  assign bus.cdb_mispred    = cdb_mispred_reg;
  assign bus.cdb_branch_loc = cdb_loc_reg;
  assign bus.pending_cnt    = pending_reg;
endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Completion-side driver of the common data bus for the out-of-order core. It accepts finished results from the functional units, holds them in per-unit slots, and picks the oldest pending result by ROB order. It drives one registered broadcast per cycle (tag, value, misprediction info), which the ROB, RS and map table consume. On a branch squash it discards every buffered result younger than the mispredicted branch.

## Interface
Parameters:
- NUM_FU, 4, number of functional-unit completion ports
- Q_DEPTH, 2, result slots per functional unit
- ROB_SZ, 8, ROB entries; valid tags are 1..ROB_SZ, tag 0 means "no tag"
- XLEN, 32, result width
- TAG_W, $clog2(ROB_SZ+1), tag width
- CNT_W, $clog2(NUM_FU*Q_DEPTH+1), occupancy counter width

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- fu_valid  in  NUM_FU  unit i presents a completed result
- fu_tag  in  NUM_FU*TAG_W  ROB tag per unit; unit i occupies bits [i*TAG_W +: TAG_W]
- fu_value  in  NUM_FU*XLEN  result value per unit
- fu_mispred  in  NUM_FU  branch result was mispredicted
- fu_branch_loc  in  NUM_FU*XLEN  resolved branch target per unit
- fu_ready  out  NUM_FU  unit i has at least one free slot
- rob_head  in  TAG_W  current ROB head tag; the age reference
- branch_valid  in  1  squash request this cycle
- branch_tag  in  TAG_W  tag of the mispredicted branch
- cdb_tag  out  TAG_W  broadcast tag; 0 = no broadcast
- cdb_v  out  XLEN  broadcast value
- cdb_mispred  out  1  broadcast misprediction flag
- cdb_branch_loc  out  XLEN  broadcast branch target
- pending_cnt  out  CNT_W  number of valid slots

## Operation
- Storage: NUM_FU×Q_DEPTH slots. Each slot holds {valid, tag, value, mispred, branch_loc}. Slots for unit i are private to unit i.
- Age: age(t) = (t − rob_head + ROB_SZ) mod ROB_SZ, computed as unsigned with TAG_W+1 bits. The head has age 0, and a smaller age is older.
- Accept: fu_valid[i] && fu_ready[i] at the edge writes the lowest-index free slot of unit i. If fu_valid[i] is high while fu_ready[i] is low, the result is not taken, and the unit must hold its result.
- fu_ready[i] = OR of ~valid over unit i's slots. It is computed only from current state, with no same-cycle pop bypass.
- Select: among all valid slots, pick the minimum age. Tags are unique, so there are no ties. On the edge, the selected slot is cleared and its fields are loaded into the cdb_* registers. If no slot is valid, cdb_tag, cdb_v, cdb_mispred and cdb_branch_loc are loaded with 0.
- Squash when branch_valid=1 at the edge:
  - Every valid slot with age(tag) > age(branch_tag) is invalidated.
  - An incoming result from that edge with age > age(branch_tag) is discarded. The handshake still counts as complete.
  - If the selected winner is younger than the branch, it is dropped and cdb_* load 0. In that case, no other slot is broadcast on that edge.
  - The branch tag itself and all older tags survive.
- pending_cnt: registered count of valid slots after the edge's accepts, pops and squashes.
- A duplicate tag, or tag 0 with fu_valid, is a protocol violation and its behaviour is undefined. Tag 0 must never be broadcast from a slot.

## Timing
- Reset (reset=0) takes effect immediately, asynchronously:
  - all slots are invalid
  - cdb_tag=0, cdb_v=0, cdb_mispred=0, cdb_branch_loc=0, pending_cnt=0
  - fu_ready is all-ones
- Reset mid-operation discards all buffered results, with no broadcast of them.
- Latency: a result accepted at edge k is broadcast at the earliest after edge k+1, when it becomes visible on cdb_*. There is no flow-through from fu_* to cdb_*.
- Each cdb_* value holds for exactly one cycle. Consumers sample it at the following edge.
- Throughput: one broadcast per cycle. An FU whose slots stay full sees fu_ready=0 until one of its slots wins.
- At the same edge, a unit's slot can be popped while that unit has an accept into a different, already-free slot. A slot freed on an edge can be refilled starting on the next edge.
- Wrap-around: the age math must order tags correctly across the ROB_SZ→1 boundary (e.g. head=7: 7<8<1<2).

## Test plan
- Single result: reset, rob_head=1, fu_valid[0]=1 with tag 3, value 0xDEAD for one cycle -> fu_ready[0] stays 1, pending_cnt=1 for one cycle, then cdb_tag=3 and cdb_v=0xDEAD for exactly one cycle, then cdb_tag=0.
- Age priority with wrap: rob_head=7, tags 2 (FU0), 8 (FU1) and 7 (FU2) accepted on the same edge -> broadcasts on three consecutive cycles in the order 7, 8, 2.
- Backpressure: Q_DEPTH=2, FU1 presents tags 4, 5, 6 back-to-back while FU0 holds older tags 2 and 3 -> fu_ready[1]=0 after the second accept, and tag 6 is accepted only on the edge after tag 4 is broadcast. The broadcast order is 2, 3, 4, 5, 6.
- Squash: rob_head=1, slots hold tags 2, 4, 6, branch_valid=1 with branch_tag=4 on the edge that selects 2 -> 2 is broadcast, 6 is dropped, pending_cnt=1, and the next broadcast is 4 followed by cdb_tag=0. An FU0 result with tag 5 arriving on the squash edge is discarded.
- Squash of the winner: only tag 5 is pending, branch_valid=1 with branch_tag=3 -> cdb_tag=0 and pending_cnt=0 after the edge.
- Async reset mid-stream: pending_cnt=3, pull reset low between edges -> all cdb_* become 0 and pending_cnt=0 without waiting for a clock edge. After release, there are no broadcasts until a new accept.
